cfg_info_responder: RTL and testbench

CFG_INFO_RESPONDER -- requirements
Module: cfg_info_responder

---
 rtl/cfg_info_pkg.sv | 89 ++++++++
 rtl/cfg_info_responder_if.sv | 37 +++
 rtl/cfg_info_decode.sv | 51 +++++
 rtl/cfg_info_responder.sv | 142 ++++++++++++++
 tb/tb_cfg_info_responder.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/cfg_info_pkg.sv
// Shared types and constants for the configuration-info responder:
// the packed configuration record, its default value, the register
// offsets of the read-only info map and the AXI response codes.
package cfg_info_pkg;

  typedef struct packed {
    logic [31:0] xlen;
    logic        isa_a;
    logic        isa_b;
    logic        isa_c;
    logic        isa_d;
    logic        isa_f;
    logic        isa_h;
    logic        isa_v;
    logic        isa_zcb;
    logic [31:0] icache_bytes;
    logic [15:0] icache_assoc;
    logic [15:0] icache_line;
    logic [31:0] dcache_bytes;
    logic [15:0] dcache_assoc;
    logic [15:0] dcache_line;
    logic [7:0]  pmp_entries;
    logic [7:0]  sb_entries;
    logic [7:0]  ras_depth;
    logic [31:0] btb_entries;
    logic [31:0] bht_entries;
  } cfg_info_t;

  localparam cfg_info_t CFG_DEFAULT = '{
    xlen:         32'd32,
    isa_a:        1'b1,
    isa_b:        1'b1,
    isa_c:        1'b1,
    isa_d:        1'b0,
    isa_f:        1'b0,
    isa_h:        1'b0,
    isa_v:        1'b0,
    isa_zcb:      1'b0,
    icache_bytes: 32'd16384,
    icache_assoc: 16'd4,
    icache_line:  16'd128,
    dcache_bytes: 32'd32768,
    dcache_assoc: 16'd8,
    dcache_line:  16'd128,
    pmp_entries:  8'd8,
    sb_entries:   8'd8,
    ras_depth:    8'd2,
    btb_entries:  32'd32,
    bht_entries:  32'd128
  };

  localparam logic [31:0] CFG_ID = 32'hCA6C_0001;

  // Word offsets of the register map
  localparam logic [31:0] OFF_ID          = 32'h00;
  localparam logic [31:0] OFF_XLEN        = 32'h04;
  localparam logic [31:0] OFF_ISA         = 32'h08;
  localparam logic [31:0] OFF_ICACHE_SIZE = 32'h0C;
  localparam logic [31:0] OFF_ICACHE_GEOM = 32'h10;
  localparam logic [31:0] OFF_DCACHE_SIZE = 32'h14;
  localparam logic [31:0] OFF_DCACHE_GEOM = 32'h18;
  localparam logic [31:0] OFF_TOPO        = 32'h1C;
  localparam logic [31:0] OFF_BTB         = 32'h20;
  localparam logic [31:0] OFF_BHT         = 32'h24;
  localparam logic [31:0] OFF_SCRATCH     = 32'h28;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {R_IDLE, R_RESP} rd_state_e;
  typedef enum logic {W_IDLE, W_RESP} wr_state_e;

  // ISA extension flags packed at their misa-style bit positions
  function automatic logic [31:0] isa_word(cfg_info_t c);
    logic [31:0] w;
    w     = '0;
    w[0]  = c.isa_a;
    w[1]  = c.isa_b;
    w[2]  = c.isa_c;
    w[3]  = c.isa_d;
    w[5]  = c.isa_f;
    w[7]  = c.isa_h;
    w[21] = c.isa_v;
    w[25] = c.isa_zcb;
    return w;
  endfunction

endpackage

// File: rtl/cfg_info_responder_if.sv
// AXI4-Lite subordinate bundle for the config-info responder.
// slave modport is the responder side, master the requester side.
interface cfg_info_responder_if #(
  parameter int AddrWidth = 12
);
  logic [AddrWidth-1:0] araddr_i;
  logic                 arvalid_i;
  logic                 arready_o;
  logic [31:0]          rdata_o;
  logic [1:0]           rresp_o;
  logic                 rvalid_o;
  logic                 rready_i;
  logic [AddrWidth-1:0] awaddr_i;
  logic                 awvalid_i;
  logic                 awready_o;
  logic [31:0]          wdata_i;
  logic [3:0]           wstrb_i;
  logic                 wvalid_i;
  logic                 wready_o;
  logic [1:0]           bresp_o;
  logic                 bvalid_o;
  logic                 bready_i;

  modport slave (
    input  araddr_i, arvalid_i, rready_i,
    input  awaddr_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
    output arready_o, rdata_o, rresp_o, rvalid_o,
    output awready_o, wready_o, bresp_o, bvalid_o
  );

  modport master (
    output araddr_i, arvalid_i, rready_i,
    output awaddr_i, awvalid_i, wdata_i, wstrb_i, wvalid_i, bready_i,
    input  arready_o, rdata_o, rresp_o, rvalid_o,
    input  awready_o, wready_o, bresp_o, bvalid_o
  );
endinterface

// File: rtl/cfg_info_decode.sv
// Combinational address -> {data, hit, writable} lookup of the info map.
// Byte-offset bits [1:0] are ignored here; alignment is judged by the caller.
// Optional feature: CFG_INFO_SCRATCH_EN maps a writable scratch word at 0x28.
module cfg_info_decode
  import cfg_info_pkg::*;
#(
  parameter int        AddrWidth = 12,
  parameter cfg_info_t CfgWords  = CFG_DEFAULT
) (
  input  logic [AddrWidth-1:0] addr_i,
`ifdef CFG_INFO_SCRATCH_EN
  input  logic [31:0]          scratch_i,
`endif
  output logic [31:0]          data_o,
  output logic                 hit_o,
  output logic                 writable_o
);

  logic [31:0] word_addr;

  // Word-aligned lookup; anything not listed is unmapped
  always_comb begin
    word_addr                  = '0;
    word_addr[AddrWidth-1:0]   = addr_i;
    word_addr[1:0]             = 2'b00;
    data_o                     = '0;
    hit_o                      = 1'b1;
    writable_o                 = 1'b0;
    case (word_addr)
      OFF_ID:          data_o = CFG_ID;
      OFF_XLEN:        data_o = CfgWords.xlen;
      OFF_ISA:         data_o = isa_word(CfgWords);
      OFF_ICACHE_SIZE: data_o = CfgWords.icache_bytes;
      OFF_ICACHE_GEOM: data_o = {CfgWords.icache_line, CfgWords.icache_assoc};
      OFF_DCACHE_SIZE: data_o = CfgWords.dcache_bytes;
      OFF_DCACHE_GEOM: data_o = {CfgWords.dcache_line, CfgWords.dcache_assoc};
      OFF_TOPO:        data_o = {8'h00, CfgWords.ras_depth,
                                 CfgWords.sb_entries, CfgWords.pmp_entries};
      OFF_BTB:         data_o = CfgWords.btb_entries;
      OFF_BHT:         data_o = CfgWords.bht_entries;
`ifdef CFG_INFO_SCRATCH_EN
      OFF_SCRATCH: begin
        data_o     = scratch_i;
        writable_o = 1'b1;
      end
`endif
      default:         hit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cfg_info_responder.sv
// AXI4-Lite subordinate exposing the core configuration record as a
// read-only register map. Independent read and write FSMs, each with a
// single outstanding transaction and a registered response.
// Optional feature: CFG_INFO_SCRATCH_EN adds a byte-writable scratch word at 0x28.
module cfg_info_responder
  import cfg_info_pkg::*;
#(
  parameter int        AddrWidth = 12,
  parameter cfg_info_t CfgWords  = CFG_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  cfg_info_responder_if.slave   bus
);

  rd_state_e   rstate_q, rstate_d;
  logic [31:0] rdata_q,  rdata_d;
  logic [1:0]  rresp_q,  rresp_d;
  wr_state_e   wstate_q, wstate_d;
  logic [1:0]  bresp_q,  bresp_d;
  logic [31:0] scratch;
  logic [31:0] rd_data, wr_data_unused;
  logic        rd_hit, rd_wr_unused, wr_hit, wr_writable;
  logic        aw_pair;

`ifdef CFG_INFO_SCRATCH_EN
  logic [31:0] scratch_q, scratch_d;
  assign scratch = scratch_q;
`else
  logic unused_wdata;
  assign scratch      = '0;
  assign unused_wdata = ^{bus.wdata_i, bus.wstrb_i, scratch};
`endif

  cfg_info_decode #(.AddrWidth(AddrWidth), .CfgWords(CfgWords)) u_rd_dec (
    .addr_i     (bus.araddr_i),
`ifdef CFG_INFO_SCRATCH_EN
    .scratch_i  (scratch),
`endif
    .data_o     (rd_data),
    .hit_o      (rd_hit),
    .writable_o (rd_wr_unused)
  );

  cfg_info_decode #(.AddrWidth(AddrWidth), .CfgWords(CfgWords)) u_wr_dec (
    .addr_i     (bus.awaddr_i),
`ifdef CFG_INFO_SCRATCH_EN
    .scratch_i  (scratch),
`endif
    .data_o     (wr_data_unused),
    .hit_o      (wr_hit),
    .writable_o (wr_writable)
  );

  // AW and W are only ever taken together
  assign aw_pair        = bus.awvalid_i && bus.wvalid_i;
  assign bus.arready_o  = (rstate_q == R_IDLE) && !rst_i;
  assign bus.awready_o  = (wstate_q == W_IDLE) && aw_pair && !rst_i;
  assign bus.wready_o   = bus.awready_o;
  assign bus.rvalid_o   = (rstate_q == R_RESP);
  assign bus.bvalid_o   = (wstate_q == W_RESP);
  assign bus.rdata_o    = rdata_q;
  assign bus.rresp_o    = rresp_q;
  assign bus.bresp_o    = bresp_q;

  // Read FSM: capture response on AR handshake, hold until R handshake
  always_comb begin
    rstate_d = rstate_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rstate_q)
      R_IDLE: if (bus.arvalid_i) begin
        rstate_d = R_RESP;
        if (bus.araddr_i[1:0] != 2'b00) begin
          rresp_d = RESP_SLVERR;
          rdata_d = '0;
        end else if (!rd_hit) begin
          rresp_d = RESP_DECERR;
          rdata_d = '0;
        end else begin
          rresp_d = RESP_OKAY;
          rdata_d = rd_data;
        end
      end
      R_RESP: if (bus.rready_i) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  // Write FSM: judge the access on AW/W handshake, hold B until accepted.
  // Scratch sees the write only on an OKAY response.
  always_comb begin
    wstate_d = wstate_q;
    bresp_d  = bresp_q;
`ifdef CFG_INFO_SCRATCH_EN
    scratch_d = scratch_q;
`endif
    case (wstate_q)
      W_IDLE: if (aw_pair) begin
        wstate_d = W_RESP;
        if (bus.awaddr_i[1:0] != 2'b00) bresp_d = RESP_SLVERR;
        else if (!wr_hit)               bresp_d = RESP_DECERR;
        else if (!wr_writable)          bresp_d = RESP_SLVERR;
        else begin
          bresp_d = RESP_OKAY;
`ifdef CFG_INFO_SCRATCH_EN
          for (int b = 0; b < 4; b++)
            if (bus.wstrb_i[b]) scratch_d[b*8 +: 8] = bus.wdata_i[b*8 +: 8];
`endif
        end
      end
      W_RESP: if (bus.bready_i) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  // State and response registers, synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rstate_q <= R_IDLE;
      rdata_q  <= '0;
      rresp_q  <= '0;
      wstate_q <= W_IDLE;
      bresp_q  <= '0;
    end else begin
      rstate_q <= rstate_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      wstate_q <= wstate_d;
      bresp_q  <= bresp_d;
    end
  end

`ifdef CFG_INFO_SCRATCH_EN
  // Scratch word storage
  always_ff @(posedge clk_i) begin
    if (rst_i) scratch_q <= '0;
    else       scratch_q <= scratch_d;
  end
`endif

endmodule

// File: tb/tb_cfg_info_responder.sv
// Directed bench for cfg_info_responder: table of reads and writes with
// hand-computed results, plus sequences for back-pressure, same-cycle
// scratch access and reset during pending responses.
// Follows CFG_INFO_SCRATCH_EN for scratch-dependent expectations.
module tb_cfg_info_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  cfg_info_responder_if #(.AddrWidth(12)) bus ();

  cfg_info_responder #(.AddrWidth(12)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

`ifdef CFG_INFO_SCRATCH_EN
  localparam logic [1:0] SCR_RESP = 2'b00;
  localparam bit         SCR_ON   = 1'b1;
`else
  localparam logic [1:0] SCR_RESP = 2'b11;
  localparam bit         SCR_ON   = 1'b0;
`endif

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_vec_t;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
  } wr_vec_t;

  rd_vec_t rv[14];
  wr_vec_t wv[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: handshake never came", name);
  endtask

  task automatic do_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] r);
    int n = 0;
    @(negedge clk);
    bus.araddr_i  = a;
    bus.arvalid_i = 1'b1;
    bus.rready_i  = 1'b1;
    while (!bus.arready_o && n < 16) begin @(negedge clk); n++; end
    if (!bus.arready_o) timeout("ar_wait");
    @(negedge clk);
    bus.arvalid_i = 1'b0;
    check("rd_latency", {31'd0, bus.rvalid_o}, 32'd1);
    d = bus.rdata_o;
    r = bus.rresp_o;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] r);
    int n = 0;
    @(negedge clk);
    bus.awaddr_i  = a;
    bus.wdata_i   = d;
    bus.wstrb_i   = s;
    bus.awvalid_i = 1'b1;
    bus.wvalid_i  = 1'b1;
    bus.bready_i  = 1'b1;
    while (!bus.awready_o && n < 16) begin @(negedge clk); n++; end
    if (!bus.awready_o) timeout("aw_wait");
    @(negedge clk);
    bus.awvalid_i = 1'b0;
    bus.wvalid_i  = 1'b0;
    check("wr_latency", {31'd0, bus.bvalid_o}, 32'd1);
    r = bus.bresp_o;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;

    rv[0]  = '{12'h000, 32'hCA6C_0001, 2'b00};
    rv[1]  = '{12'h004, 32'h0000_0020, 2'b00};
    rv[2]  = '{12'h008, 32'h0000_0007, 2'b00};
    rv[3]  = '{12'h00C, 32'h0000_4000, 2'b00};
    rv[4]  = '{12'h010, 32'h0080_0004, 2'b00};
    rv[5]  = '{12'h014, 32'h0000_8000, 2'b00};
    rv[6]  = '{12'h018, 32'h0080_0008, 2'b00};
    rv[7]  = '{12'h01C, 32'h0002_0808, 2'b00};
    rv[8]  = '{12'h020, 32'h0000_0020, 2'b00};
    rv[9]  = '{12'h024, 32'h0000_0080, 2'b00};
    rv[10] = '{12'h006, 32'h0000_0000, 2'b10};
    rv[11] = '{12'h100, 32'h0000_0000, 2'b11};
    rv[12] = '{12'h02C, 32'h0000_0000, 2'b11};
    rv[13] = '{12'hFFC, 32'h0000_0000, 2'b11};

    wv[0] = '{12'h004, 32'hFFFF_FFFF, 4'hF, 2'b10};
    wv[1] = '{12'h000, 32'h1234_5678, 4'hF, 2'b10};
    wv[2] = '{12'h02A, 32'hDEAD_BEEF, 4'hF, 2'b10};
    wv[3] = '{12'h040, 32'hDEAD_BEEF, 4'hF, 2'b11};

    bus.araddr_i  = '0; bus.arvalid_i = 1'b0; bus.rready_i = 1'b0;
    bus.awaddr_i  = '0; bus.awvalid_i = 1'b1; bus.wvalid_i = 1'b1;
    bus.wdata_i   = '0; bus.wstrb_i   = '0;   bus.bready_i = 1'b0;

    // Reset state, with AW/W offered to show they are refused in reset
    repeat (2) @(negedge clk);
    check("rst_arready", {31'd0, bus.arready_o}, 32'd0);
    check("rst_awready", {31'd0, bus.awready_o}, 32'd0);
    check("rst_wready",  {31'd0, bus.wready_o},  32'd0);
    check("rst_rvalid",  {31'd0, bus.rvalid_o},  32'd0);
    check("rst_bvalid",  {31'd0, bus.bvalid_o},  32'd0);
    check("rst_rdata",   bus.rdata_o,            32'd0);
    check("rst_rresp",   {30'd0, bus.rresp_o},   32'd0);
    check("rst_bresp",   {30'd0, bus.bresp_o},   32'd0);
    bus.awvalid_i = 1'b0;
    bus.wvalid_i  = 1'b0;
    rst = 1'b0;

    // AW without W must not be accepted
    @(negedge clk);
    bus.awvalid_i = 1'b1;
    #1;
    check("aw_alone_awready", {31'd0, bus.awready_o}, 32'd0);
    check("idle_arready",     {31'd0, bus.arready_o}, 32'd1);
    bus.awvalid_i = 1'b0;

    // Same-cycle read and write of scratch: read sees pre-write value
    @(negedge clk);
    bus.araddr_i = 12'h028; bus.arvalid_i = 1'b1; bus.rready_i = 1'b1;
    bus.awaddr_i = 12'h028; bus.wdata_i = 32'hA5A5_A5A5; bus.wstrb_i = 4'b0101;
    bus.awvalid_i = 1'b1; bus.wvalid_i = 1'b1; bus.bready_i = 1'b1;
    #1;
    check("same_arready", {31'd0, bus.arready_o}, 32'd1);
    check("same_awready", {31'd0, bus.awready_o}, 32'd1);
    @(negedge clk);
    bus.arvalid_i = 1'b0; bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0;
    check("same_rvalid", {31'd0, bus.rvalid_o}, 32'd1);
    check("same_bvalid", {31'd0, bus.bvalid_o}, 32'd1);
    check("same_rdata",  bus.rdata_o,            32'd0);
    check("same_rresp",  {30'd0, bus.rresp_o},   {30'd0, SCR_RESP});
    check("same_bresp",  {30'd0, bus.bresp_o},   {30'd0, SCR_RESP});
    do_read(12'h028, d, r);
    check("scratch_rdata", d, SCR_ON ? 32'h00A5_00A5 : 32'h0);
    check("scratch_rresp", {30'd0, r}, {30'd0, SCR_RESP});

    // Read table
    for (int i = 0; i < 14; i++) begin
      do_read(rv[i].addr, d, r);
      check($sformatf("rd_data@%03h", rv[i].addr), d, rv[i].data);
      check($sformatf("rd_resp@%03h", rv[i].addr), {30'd0, r}, {30'd0, rv[i].resp});
    end

    // Write table: no write to a read-only word may take effect
    for (int i = 0; i < 4; i++) begin
      do_write(wv[i].addr, wv[i].data, wv[i].strb, r);
      check($sformatf("wr_resp@%03h", wv[i].addr), {30'd0, r}, {30'd0, wv[i].resp});
    end
    do_read(12'h004, d, r);
    check("xlen_after_wr", d, 32'h0000_0020);
    do_read(12'h000, d, r);
    check("id_after_wr", d, 32'hCA6C_0001);

    // Back-pressure on R: response held, no new AR taken
    @(negedge clk);
    bus.araddr_i = 12'h018; bus.arvalid_i = 1'b1; bus.rready_i = 1'b0;
    @(negedge clk);
    bus.arvalid_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("bp_rvalid",  {31'd0, bus.rvalid_o},  32'd1);
      check("bp_rdata",   bus.rdata_o,            32'h0080_0008);
      check("bp_arready", {31'd0, bus.arready_o}, 32'd0);
      @(negedge clk);
    end
    bus.rready_i = 1'b1;
    @(negedge clk);
    check("bp_release_rvalid",  {31'd0, bus.rvalid_o},  32'd0);
    check("bp_release_arready", {31'd0, bus.arready_o}, 32'd1);

    // Reset while both responses pending; scratch returns to zero
    do_write(12'h028, 32'hFFFF_FFFF, 4'hF, r);
    check("scr_full_bresp", {30'd0, r}, {30'd0, SCR_RESP});
    @(negedge clk);
    bus.araddr_i = 12'h000; bus.arvalid_i = 1'b1; bus.rready_i = 1'b0;
    bus.awaddr_i = 12'h004; bus.awvalid_i = 1'b1; bus.wvalid_i = 1'b1; bus.bready_i = 1'b0;
    @(negedge clk);
    bus.arvalid_i = 1'b0; bus.awvalid_i = 1'b0; bus.wvalid_i = 1'b0;
    check("pre_rst_rvalid", {31'd0, bus.rvalid_o}, 32'd1);
    check("pre_rst_bvalid", {31'd0, bus.bvalid_o}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_rvalid",  {31'd0, bus.rvalid_o},  32'd0);
    check("mid_rst_bvalid",  {31'd0, bus.bvalid_o},  32'd0);
    check("mid_rst_arready", {31'd0, bus.arready_o}, 32'd0);
    check("mid_rst_rdata",   bus.rdata_o,            32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_arready", {31'd0, bus.arready_o}, 32'd1);
    do_read(12'h028, d, r);
    check("post_rst_scratch", d, 32'd0);
    check("post_rst_scr_resp", {30'd0, r}, {30'd0, SCR_RESP});

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
